mai_forward_addr_gen: RTL
=========================

# mai_forward_addr_gen

Sprite address generator for Mai's forward-walk animation. It sits directly upstream of the sprite pixel stage and converts the current VGA draw coordinate, the sprite's on-screen position and the current animation frame into the 16-bit sprite ROM address and an in-sprite flag. It sequences the walk animation across video frames. Sprite position and walk state are latched once per video frame so the image never tears mid-scan.

## Interface
Parameters:
- SPR_W, 80: sprite width in pixels.
- SPR_H, 120: sprite height in pixels.
- N_FRAMES, 6: animation frames stored back-to-back in ROM. N_FRAMES*SPR_W*SPR_H must be ≤ 65536.
- FRAME_HOLD, 6: video frames each animation frame is displayed.

Ports:
- vga_clk, input, 1: pixel clock; all state updates on its rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- frame_start, input, 1: one-cycle pulse at start of vertical blank.
- draw_x, input, 10: current scan x coordinate.
- draw_y, input, 10: current scan y coordinate.
- sprite_x, input, 10: sprite top-left x, sampled at frame_start.
- sprite_y, input, 10: sprite top-left y, sampled at frame_start.
- walk, input, 1: 1 = animate, 0 = stand on frame 0; sampled at frame_start.
- rom_address, output, 16: sprite ROM address, registered.
- in_sprite, output, 1: current pixel lies inside the sprite box, registered, aligned with rom_address.
- anim_frame, output, 3: current animation frame index.

## Operation
- Shadow registers sx, sy, walk_q load sprite_x, sprite_y and walk on frame_start. They are used for all address math until the next frame_start.
- Animation FSM has two states:
  - IDLE: anim_frame=0, hold=0. On frame_start with walk=1, go to WALK. anim_frame is still 0 on entry.
  - WALK: on each frame_start with walk=1, hold increments. When hold==FRAME_HOLD-1, hold becomes 0 and anim_frame advances, wrapping from N_FRAMES-1 to 0.
  - WALK, frame_start with walk=0: go to IDLE, anim_frame=0, hold=0.
- frame_start with no walk change in IDLE leaves all state unchanged.
- Hit test: compute sx+SPR_W and sy+SPR_H in 11 bits so there is no wrap near screen edge 639/479.
  - hit = (draw_x ≥ sx) & (draw_x < sx+SPR_W) & (draw_y ≥ sy) & (draw_y < sy+SPR_H).
  - No clipping is needed; off-screen parts are simply never scanned.
- Address: rel_x = draw_x−sx, rel_y = draw_y−sy.
  - addr = anim_frame*SPR_W*SPR_H + rel_y*SPR_W + rel_x, computed in 17 bits and truncated to 16.
  - Multiplies by constants are permitted; the base offset may be held in a register updated with anim_frame.
- When hit=0: rom_address=0 and in_sprite=0.

## Timing
- Reset (async, reset_n=0): rom_address=0, in_sprite=0, anim_frame=0, FSM=IDLE, hold=0, sx=sy=0, walk_q=0.
- Latency: draw_x/draw_y presented at edge N produce rom_address and in_sprite valid after edge N+1 (one register stage).
- The downstream ROM samples on the falling edge and its palette output is registered on the next rising edge, so one pixel of total pipeline lag is expected. Upstream counters are not compensated.
- Shadow registers and FSM update on the same edge as frame_start. Addresses from the following cycle onward use the new values.
- frame_start during active video (illegal by contract) is still honoured immediately; no guard is required.
- Reset asserted mid-animation: everything returns to the reset values immediately. After release, the block waits for the next frame_start.

## Test plan
- Reset, then frame_start with sprite_x=100, sprite_y=200, walk=0; draw (100,200) → one cycle later rom_address=0, in_sprite=1.
- Same setup, draw (179,319) → rom_address=9599, in_sprite=1; draw (180,200) → rom_address=0, in_sprite=0; draw (99,250) → in_sprite=0.
- walk=1, issue 12 frame_starts → anim_frame=2; draw (105,210) → rom_address=20005.
- walk=1 for 36 consecutive frame_starts → anim_frame steps 0,1,…,5 every 6 pulses and returns to 0 at pulse 36 (first-pulse IDLE→WALK counted per the FSM rule; the bench checks against a reference model).
- sprite_x=600, sprite_y=400, draw (639,479) → in_sprite=1, rom_address=79*80+39=6359; no false hits at draw_x 0–40 (checks 11-bit bound).
- Assert reset_n=0 mid-walk at anim_frame=4 → anim_frame, rom_address, in_sprite all 0 asynchronously. After release, frame_start with walk=0 keeps anim_frame=0.

Source files
------------

// File: rtl/mai_forward_addr_gen_if.sv
// Bundle between the VGA timing/sprite logic and Mai's forward-walk address generator.
// master drives scan position and sprite state; slave returns the ROM address.
interface mai_forward_addr_gen_if;
  logic        frame_start;
  logic [9:0]  draw_x;
  logic [9:0]  draw_y;
  logic [9:0]  sprite_x;
  logic [9:0]  sprite_y;
  logic        walk;
  logic [15:0] rom_address;
  logic        in_sprite;
  logic [2:0]  anim_frame;

  modport master (
    output frame_start,
    output draw_x,
    output draw_y,
    output sprite_x,
    output sprite_y,
    output walk,
    input  rom_address,
    input  in_sprite,
    input  anim_frame
  );

  modport slave (
    input  frame_start,
    input  draw_x,
    input  draw_y,
    input  sprite_x,
    input  sprite_y,
    input  walk,
    output rom_address,
    output in_sprite,
    output anim_frame
  );
endinterface

// File: rtl/mai_forward_addr_gen.sv
// Sprite ROM address generator for Mai's forward walk.
// Position and walk state are latched per video frame to avoid tearing.
module mai_forward_addr_gen #(
  parameter int SPR_W      = 80,
  parameter int SPR_H      = 120,
  parameter int N_FRAMES   = 6,
  parameter int FRAME_HOLD = 6
) (
  input logic                  vga_clk,
  input logic                  reset_n,
  mai_forward_addr_gen_if.slave bus
);

  localparam int FRAME_SZ = SPR_W * SPR_H;
  localparam int HW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WALK = 1'b1;

  logic [9:0]    sx_q;
  logic [9:0]    sy_q;
  logic [0:0]    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d, hold_cur;
  logic [2:0]    frame_q, frame_d;
  logic [16:0]   base_q, base_d;
  logic [15:0]   addr_q;
  logic          hit_q;

  // state_q doubles as the latched walk flag: WALK iff walk was 1 last frame_start
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      sx_q <= '0;
      sy_q <= '0;
    end else if (bus.frame_start) begin
      sx_q <= bus.sprite_x;
      sy_q <= bus.sprite_y;
    end
  end

  assign hold_cur = (state_q == IDLE) ? '0 : hold_q;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    frame_d = frame_q;
    base_d  = base_q;
    if (bus.frame_start) begin
      if (bus.walk) begin
        state_d = WALK;
        if (hold_cur == HW'(FRAME_HOLD - 1)) begin
          hold_d = '0;
          if (frame_q == 3'(N_FRAMES - 1)) begin
            frame_d = '0;
            base_d  = '0;
          end else begin
            frame_d = frame_q + 3'd1;
            base_d  = base_q + 17'(FRAME_SZ);
          end
        end else begin
          hold_d = hold_cur + HW'(1);
        end
      end else begin
        state_d = IDLE;
        hold_d  = '0;
        frame_d = '0;
        base_d  = '0;
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      frame_q <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      frame_q <= frame_d;
      base_q  <= base_d;
    end
  end

  // 11-bit bounds so a sprite hugging x=639 / y=479 cannot wrap
  logic [10:0] x_end, y_end;
  logic        hit;
  logic [9:0]  rel_x, rel_y;
  logic [16:0] addr;

  assign x_end = {1'b0, sx_q} + 11'(SPR_W);
  assign y_end = {1'b0, sy_q} + 11'(SPR_H);

  assign hit = ({1'b0, bus.draw_x} >= {1'b0, sx_q})
             & ({1'b0, bus.draw_x} <  x_end)
             & ({1'b0, bus.draw_y} >= {1'b0, sy_q})
             & ({1'b0, bus.draw_y} <  y_end);

  assign rel_x = bus.draw_x - sx_q;
  assign rel_y = bus.draw_y - sy_q;
  assign addr  = base_q
               + 17'(rel_y) * 17'(SPR_W)
               + 17'(rel_x);

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      hit_q  <= 1'b0;
    end else begin
      hit_q  <= hit;
      addr_q <= hit ? addr[15:0] : 16'd0;
    end
  end

  assign bus.rom_address = addr_q;
  assign bus.in_sprite   = hit_q;
  assign bus.anim_frame  = frame_q;

endmodule
